// File: rtl/multi_edge_detect.sv
// Multi-channel edge detector: per-channel synchroniser, hold-time glitch filter,
// mode-qualified edge events reported as a pulse, a sticky bit and a saturating counter.
module multi_edge_detect #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 3,
  parameter int CNT_W       = 8
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic [CH-1:0]         din,
  input  logic [2*CH-1:0]       mode,
  input  logic [CH-1:0]         clr,
  input  logic [CH-1:0]         cnt_clr,
  output logic [CH-1:0]         level,
  output logic [CH-1:0]         flag,
  output logic [CH-1:0]         sticky,
  output logic [CH*CNT_W-1:0]   count
);

  localparam int FCNT_W = (FILT_CYC < 1) ? 1 : $clog2(FILT_CYC + 1);
  localparam logic [FCNT_W-1:0] FILT_MAX = FCNT_W'(FILT_CYC);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_p0;
    logic [FCNT_W-1:0]      fcnt_p1;
    logic                   level_p1;
    logic                   flag_p2;
    logic                   sticky_p2;
    logic [CNT_W-1:0]       count_p2;
    logic                   s;
    logic                   accept;
    logic                   evt;
    logic [1:0]             md;

    assign md     = mode[2*i +: 2];
    assign s      = sync_p0[SYNC_STAGES-1];
    assign accept = (s != level_p1) && (fcnt_p1 == FILT_MAX);
    // s is the new level at acceptance, so it tells rising (1) from falling (0).
    assign evt    = accept && (s ? md[0] : md[1]);

    always_ff @(posedge clock) begin
      if (rst) begin
        sync_p0   <= '0;
        fcnt_p1   <= '0;
        level_p1  <= 1'b0;
        flag_p2   <= 1'b0;
        sticky_p2 <= 1'b0;
        count_p2  <= '0;
      end else begin
        // stage p0: synchroniser chain
        sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din[i]};

        // stage p1: hold-time filter
        if (s == level_p1) begin
          fcnt_p1 <= '0;
        end else if (fcnt_p1 == FILT_MAX) begin
          level_p1 <= s;
          fcnt_p1  <= '0;
        end else begin
          fcnt_p1 <= fcnt_p1 + FCNT_W'(1);
        end

        // stage p2: event reporting; a new event outranks either clear
        flag_p2   <= evt;
        sticky_p2 <= evt | (sticky_p2 & ~clr[i]);
        if (cnt_clr[i]) begin
          count_p2 <= evt ? CNT_W'(1) : '0;
        end else if (evt) begin
          count_p2 <= sat_inc(count_p2);
        end
      end
    end

    assign level[i]                = level_p1;
    assign flag[i]                 = flag_p2;
    assign sticky[i]               = sticky_p2;
    assign count[CNT_W*i +: CNT_W] = count_p2;
  end

endmodule

// File: tb/tb_multi_edge_detect.sv
// Directed bench for multi_edge_detect: default sync/filter depth, 2-bit counters.
module tb_multi_edge_detect;
  localparam int CH = 4;
  localparam int CW = 2;

  logic              clock = 1'b0;
  logic              rst;
  logic [CH-1:0]     din;
  logic [2*CH-1:0]   mode;
  logic [CH-1:0]     clr;
  logic [CH-1:0]     cnt_clr;
  logic [CH-1:0]     level;
  logic [CH-1:0]     flag;
  logic [CH-1:0]     sticky;
  logic [CH*CW-1:0]  count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  multi_edge_detect #(.CH(CH), .SYNC_STAGES(2), .FILT_CYC(3), .CNT_W(CW)) dut (
    .clock   (clock),
    .rst     (rst),
    .din     (din),
    .mode    (mode),
    .clr     (clr),
    .cnt_clr (cnt_clr),
    .level   (level),
    .flag    (flag),
    .sticky  (sticky),
    .count   (count)
  );

  always #5 clock = ~clock;

  // advance one rising edge; inputs are driven and outputs sampled 1 time unit later
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; din = '0; mode = '0; clr = '0; cnt_clr = '0;
    tick(3);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if ({level, flag, sticky, count} !== 20'h0) $display("FAIL reset_state: got %h want 0", {level, flag, sticky, count});
    else pass_cnt++;
    din = 4'b0001; mode = 8'b00_00_00_01;
    tick(5);
    total_cnt++;
    if (flag !== 4'b0000 || level !== 4'b0000) $display("FAIL reset_edge5: flag=%b level=%b want 0000/0000", flag, level);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (flag !== 4'b0001 || level !== 4'b0001) $display("FAIL reset_edge6: flag=%b level=%b want 0001/0001", flag, level);
    else pass_cnt++;
    total_cnt++;
    if (count !== 8'h01 || sticky !== 4'b0001) $display("FAIL reset_count: count=%h sticky=%b want 01/0001", count, sticky);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (flag !== 4'b0000) $display("FAIL reset_edge7: flag=%b want 0000", flag);
    else pass_cnt++;
  endtask

  task automatic test_modes();
    int nfl [CH];
    do_reset();
    mode = 8'b11_10_01_00;
    for (int c = 0; c < CH; c++) nfl[c] = 0;
    din = 4'hF;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      for (int c = 0; c < CH; c++) if (flag[c]) nfl[c]++;
    end
    total_cnt++;
    if (level !== 4'hF) $display("FAIL modes_level_high: got %b want 1111", level);
    else pass_cnt++;
    din = 4'h0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      for (int c = 0; c < CH; c++) if (flag[c]) nfl[c]++;
    end
    total_cnt++;
    if (nfl[0] != 0 || nfl[1] != 1 || nfl[2] != 1 || nfl[3] != 2)
      $display("FAIL modes_flags: got %0d %0d %0d %0d want 0 1 1 2", nfl[0], nfl[1], nfl[2], nfl[3]);
    else pass_cnt++;
    total_cnt++;
    if (sticky !== 4'b1110) $display("FAIL modes_sticky: got %b want 1110", sticky);
    else pass_cnt++;
    total_cnt++;
    if (count !== 8'b10_01_01_00) $display("FAIL modes_count: got %b want 10010100", count);
    else pass_cnt++;
    total_cnt++;
    if (level !== 4'h0) $display("FAIL modes_level_low: got %b want 0000", level);
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    int nfl;
    int hi_cycles;
    do_reset();
    mode = 8'b00_00_00_11;
    nfl = 0; hi_cycles = 0;
    din = 4'b0001; tick(3); din = 4'b0000;
    for (int k = 0; k < 15; k++) begin
      tick(1);
      if (flag[0]) nfl++;
      if (level[0]) hi_cycles++;
    end
    total_cnt++;
    if (nfl != 0 || hi_cycles != 0) $display("FAIL glitch_3cyc: flags=%0d level_hi=%0d want 0 0", nfl, hi_cycles);
    else pass_cnt++;
    din = 4'b0001; tick(4); din = 4'b0000;
    for (int k = 0; k < 15; k++) begin
      tick(1);
      if (flag[0]) nfl++;
      if (level[0]) hi_cycles++;
    end
    total_cnt++;
    if (nfl != 2 || hi_cycles != 4) $display("FAIL glitch_4cyc: flags=%0d level_hi=%0d want 2 4", nfl, hi_cycles);
    else pass_cnt++;
    total_cnt++;
    if (count[CW-1:0] !== 2'd2) $display("FAIL glitch_count: got %0d want 2", count[CW-1:0]);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    logic [CW-1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    mode = 8'b00_00_00_01;
    for (int e = 0; e < 5; e++) begin
      din = 4'b0001; tick(10);
      total_cnt++;
      if (count[CW-1:0] !== exp_cnt[e]) $display("FAIL sat_event%0d: got %0d want %0d", e + 1, count[CW-1:0], exp_cnt[e]);
      else pass_cnt++;
      din = 4'b0000; tick(10);
    end
    din = 4'b0001; tick(5);
    cnt_clr = 4'b0001; tick(1); cnt_clr = 4'b0000;
    total_cnt++;
    if (flag[0] !== 1'b1 || count[CW-1:0] !== 2'd1) $display("FAIL sat_clr_with_event: flag=%b count=%0d want 1 1", flag[0], count[CW-1:0]);
    else pass_cnt++;
    cnt_clr = 4'b0001; tick(1); cnt_clr = 4'b0000;
    total_cnt++;
    if (count[CW-1:0] !== 2'd0) $display("FAIL sat_clr_alone: got %0d want 0", count[CW-1:0]);
    else pass_cnt++;
  endtask

  task automatic test_clear_priority();
    do_reset();
    mode = 8'b00_00_00_01;
    din = 4'b0001; tick(5);
    clr = 4'b0001; tick(1);
    total_cnt++;
    if (flag[0] !== 1'b1 || sticky[0] !== 1'b1) $display("FAIL clr_vs_event: flag=%b sticky=%b want 1 1", flag[0], sticky[0]);
    else pass_cnt++;
    tick(1); clr = 4'b0000;
    total_cnt++;
    if (sticky[0] !== 1'b0) $display("FAIL clr_next: sticky=%b want 0", sticky[0]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int first_flag;
    do_reset();
    mode = 8'b00_00_00_01;
    din = 4'b0001; tick(4);
    rst = 1'b1; tick(1); rst = 1'b0;
    total_cnt++;
    if ({level, flag, sticky, count} !== 20'h0) $display("FAIL rstmid_state: got %h want 0", {level, flag, sticky, count});
    else pass_cnt++;
    first_flag = 0;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (flag[0] && first_flag == 0) first_flag = k;
    end
    total_cnt++;
    if (first_flag != 6) $display("FAIL rstmid_redetect: first flag after edge %0d want 6", first_flag);
    else pass_cnt++;
    total_cnt++;
    if (count[CW-1:0] !== 2'd1) $display("FAIL rstmid_count: got %0d want 1", count[CW-1:0]);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_modes();
    test_glitch();
    test_saturation();
    test_clear_priority();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/multi_edge_detect.md
# multi_edge_detect

Parametrised, multi-channel synchronous edge detector for asynchronous or noisy single-bit inputs. Each channel has a configurable synchroniser, a glitch filter with a programmable hold time, and per-channel mode select for rising, falling, both or no edges. Detected events appear as a one-cycle pulse, a sticky status bit and a saturating event counter. The block sits between external pins or cross-domain strobes and the control logic or status registers that consume edge events.

## Interface
Parameters:
- CH, 4: number of independent channels (≥1).
- SYNC_STAGES, 2: synchroniser depth per channel (≥2).
- FILT_CYC, 3: extra consecutive cycles a new level must hold before it is accepted; 0 disables filtering.
- CNT_W, 8: width of each per-channel event counter (≥1).

Ports:
- clock, in, 1: single clock; all state updates on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- din, in, CH: raw inputs, may be asynchronous to clock.
- mode, in, 2*CH: channel i uses bits [2i+1:2i]. 00 = off, 01 = rising, 10 = falling, 11 = both.
- clr, in, CH: write-1-to-clear for sticky[i].
- cnt_clr, in, CH: clears count of channel i.
- level, out, CH: filtered, synchronised level.
- flag, out, CH: one-cycle event pulse, registered.
- sticky, out, CH: latched event status.
- count, out, CH*CNT_W: channel i uses bits [CNT_W*(i+1)-1:CNT_W*i]. Saturating event count.

## Operation
- Reset: all synchroniser flops, filter counters, level, flag, sticky and count clear to 0.
  - A channel whose din is 1 after reset therefore reports a rising transition once the normal latency has elapsed.
- Synchroniser: din[i] passes through a SYNC_STAGES-deep flop chain. Its output is s[i].
- Filter, per channel, evaluated each edge. The counter fcnt is ceil(log2(FILT_CYC+1)) bits wide, minimum 1.
  - s == level: fcnt <= 0.
  - s != level and fcnt == FILT_CYC: level <= s, fcnt <= 0. This is a transition.
  - Otherwise: fcnt <= fcnt + 1.
  - Any return of s to level before acceptance resets fcnt. Pulses shorter than FILT_CYC+1 cycles in the s domain are rejected.
- Event qualification:
  - A 0→1 transition is an event if mode bit 0 = 1.
  - A 1→0 transition is an event if mode bit 1 = 1.
  - mode = 00 still tracks level but never raises an event.
- flag[i] <= event on the same edge that level updates. It is high for exactly one cycle.
  - Back-to-back transitions cannot occur closer than FILT_CYC+1 cycles apart.
- sticky[i]: set on event, cleared by clr[i]. Simultaneous event and clr: set wins, sticky stays 1.
- count[i]: increments on event and saturates at 2^CNT_W−1. cnt_clr[i] clears it to 0.
  - Simultaneous cnt_clr and event: count = 1.
- mode changes take effect on the next edge. They never disturb level or fcnt.
- Channels are fully independent. There is no cross-channel priority.

## Timing
- Let din change and remain stable before clock edge 1. Then:
  - s changes after edge SYNC_STAGES.
  - level changes after edge SYNC_STAGES+1+FILT_CYC.
  - flag is high during the following cycle.
- Defaults: level and flag update after edge 6, and flag is high until edge 7.
  - With FILT_CYC=0 and SYNC_STAGES=2: after edge 3.
- sticky and count update on the same edge as flag, i.e. the same latency.
- clr and cnt_clr take effect on the next edge. They have no combinational path to any output.
- rst asserted mid-filter or mid-pulse:
  - All state is 0 after that edge and the pending transition is discarded.
  - flag is 0 in the cycle after reset.

## Test plan
- Reset and idle: rst high 3 cycles, din=0 → level, flag, sticky and count all 0. din=1 held from reset release with mode=01 → one flag on ch0 after edge 6, count=1.
- Mode coverage: ch0..3 with mode 00, 01, 10, 11, din toggled 0→1→0 with 20-cycle spacing → flag counts of 0, 1, 1 and 2. sticky ends as 0, 1, 1, 1.
- Glitch filter (defaults): a 3-cycle high pulse on din → no level change, no flag. A 4-cycle pulse → level goes high then low, and mode 11 gives 2 flags.
- Saturation, CNT_W=2: 5 rising edges → count 1, 2, 3, 3, 3. cnt_clr pulsed together with a 6th event → count=1.
- Clear priority: clr[0]=1 on the same edge that flag[0] rises → sticky[0]=1. clr[0]=1 the next cycle → sticky[0]=0.
- Reset mid-operation: assert rst while fcnt=2 on a pending transition → no flag afterwards, all outputs 0. The transition is re-detected with full latency after release if din is still 1.
